// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and default width for the multiply/divide unit
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one shift-add multiply or restoring shift-subtract divide step on {acc, operand}
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_acc
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem;
  logic [WIDTH:0] w_diff;
  assign w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
  assign w_rem  = i_acc[2*WIDTH-1:WIDTH-1];
  // a set top bit in the difference is the borrow: keep the shifted remainder, quotient bit 0
  assign w_diff = w_rem - {1'b0, i_operand};
  assign o_acc  = !i_div    ? {w_sum, i_acc[WIDTH-1:1]} :
                  w_diff[WIDTH] ? {w_rem[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0} :
                                  {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rs;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               w_signed;
  logic               w_is_div;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [2*WIDTH-1:0] w_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic               w_dz;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div = (op == OP_DIVU) || (op == OP_DIV);
  assign w_rs_neg = w_signed & rs_data[WIDTH-1];
  assign w_rt_neg = w_signed & rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_data : rs_data;
  assign w_rt_mag = w_rt_neg ? -rt_data : rt_data;
  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_div     (r_div),
    .i_acc     (r_acc),
    .i_operand (r_b),
    .o_acc     (w_next)
  );
  // results are fixed up from the final step's combinational output so they land at the done edge
  assign w_prod = r_neg_q ? -w_next : w_next;
  assign w_q    = r_neg_q ? -w_next[WIDTH-1:0] : w_next[WIDTH-1:0];
  assign w_r    = r_neg_r ? -w_next[2*WIDTH-1:WIDTH] : w_next[2*WIDTH-1:WIDTH];
  assign w_dz   = (r_b == '0);
  assign w_hi   = !r_div ? w_prod[2*WIDTH-1:WIDTH] : w_dz ? r_rs : w_r;
  assign w_lo   = !r_div ? w_prod[WIDTH-1:0] : w_dz ? '1 : w_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_rs     <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_state  <= S_RUN;
          busy     <= 1'b1;
          r_cnt    <= '0;
          r_acc    <= {{WIDTH{1'b0}}, w_is_div ? w_rs_mag : w_rt_mag};
          r_b      <= w_is_div ? w_rt_mag : w_rs_mag;
          r_rs     <= rs_data;
          r_div    <= w_is_div;
          r_neg_q  <= w_rs_neg ^ w_rt_neg;
          r_neg_r  <= w_rs_neg;
          div_zero <= 1'b0;
        end else begin
          if (hi_we) hi <= mt_data;
          if (lo_we) lo <= mt_data;
        end
      end else if (flush) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        r_acc <= w_next;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          hi       <= w_hi;
          lo       <= w_lo;
          div_zero <= r_div & w_dz;
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table vectors, hand corner sequences and randomized ops against an arithmetic model
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] mt_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
  } vec_t;
  vec_t tab[5];
  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .mt_data(mt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  // architectural result from plain integer arithmetic
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic [63:0] p;
    longint sp;
    int sq;
    int sr;
    dz = 1'b0;
    if (o[1] && b == 0) begin
      h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
    end else if (o == 2'b00) begin
      p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0];
    end else if (o == 2'b01) begin
      sp = longint'($signed(a)) * longint'($signed(b)); p = 64'(sp); h = p[63:32]; l = p[31:0];
    end else if (o == 2'b10) begin
      l = a / b; h = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      l = 32'h8000_0000; h = 32'd0;
    end else begin
      sq = $signed(a) / $signed(b); sr = $signed(a) % $signed(b); l = 32'(sq); h = 32'(sr);
    end
  endtask
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int t0, input string nm);
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, 64'(cyc - t0), 64'd32);
  endtask
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input string nm);
    int t0;
    issue(o, a, b);
    t0 = cyc;
    chk({nm, " busy"}, 64'(busy), 64'd1);
    wait_done(t0, nm);
    chk({nm, " hi"}, 64'(hi), 64'(ehi));
    chk({nm, " lo"}, 64'(lo), 64'(elo));
    chk({nm, " div_zero"}, 64'(div_zero), 64'(edz));
  endtask
  initial begin
    logic [31:0] mh, ml;
    logic md;
    int t0;
    tab[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tab[1] = '{2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    tab[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tab[3] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    tab[4] = '{2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    #1;
    chk("reset busy", 64'(busy), 0);
    chk("reset done", 64'(done), 0);
    chk("reset hi", 64'(hi), 0);
    chk("reset lo", 64'(lo), 0);
    chk("reset div_zero", 64'(div_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "pre-reset multu");
    issue(2'b00, 32'hFFFF_FFFF, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", 64'(busy), 0);
    chk("async reset done", 64'(done), 0);
    chk("async reset hi", 64'(hi), 0);
    chk("async reset lo", 64'(lo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // table entries are issued back to back, each in the previous done cycle
    for (int i = 0; i < 5; i++)
      do_op(tab[i].op, tab[i].a, tab[i].b, tab[i].ehi, tab[i].elo, tab[i].edz, $sformatf("vec%0d", i));
    issue(2'b00, 32'd2, 32'd3);
    t0 = cyc;
    chk("dz cleared by start", 64'(div_zero), 0);
    wait_done(t0, "multu 2*3");
    chk("multu 2*3 hi", 64'(hi), 0);
    chk("multu 2*3 lo", 64'(lo), 6);
    @(negedge clk);
    issue(2'b10, 32'd17, 32'd5);
    t0 = cyc;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'd1; rt_data = 32'd1;
    hi_we = 1'b1; mt_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done(t0, "divu 17/5");
    chk("divu 17/5 hi", 64'(hi), 2);
    chk("divu 17/5 lo", 64'(lo), 3);
    @(negedge clk);
    chk("ignored start busy", 64'(busy), 0);
    hi_we = 1'b1; mt_data = 32'h11;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; mt_data = 32'h22;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'h11);
    chk("mtlo", 64'(lo), 64'h22);
    issue(2'b00, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 0);
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("flush no done", 64'(seen), 0);
    end
    chk("flush hi kept", 64'(hi), 64'h11);
    chk("flush lo kept", 64'(lo), 64'h22);
    lo_we = 1'b1; mt_data = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo idle lo", 64'(lo), 64'h55);
    chk("mtlo idle hi", 64'(hi), 64'h11);
    hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'h77;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt both hi", 64'(hi), 64'h77);
    chk("mt both lo", 64'(lo), 64'h77);
    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      logic [31:0] a, b;
      int sel;
      o = 2'($urandom);
      a = $urandom;
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : ($urandom >> $urandom_range(0, 31));
      model(o, a, b, mh, ml, md);
      do_op(o, a, b, mh, ml, md, $sformatf("rand%0d op%0d", i, o));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
